// File: rtl/montexp_pkg.sv
// Shared definitions for the Montgomery exponentiation controller and the
// multiplier wrapper: default widths and the controller state encoding.
package montexp_pkg;

    localparam int WID_DEF    = 256;
    localparam int CNTWID_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SQR_REQ,
        ST_SQR_WAIT,
        ST_MUL_REQ,
        ST_MUL_WAIT,
        ST_DONE,
        ST_SCAN
    } state_t;

endpackage

// File: rtl/montexp_ctrl_bitsel.sv
// Exponent register and bit-index counter for montexp_ctrl.
// MONTEXP_SKIPLZ_EN adds the leading-zero scan decrement.
module montexp_bitsel
    import montexp_pkg::*;
#(
    parameter int WID    = WID_DEF,
    parameter int CNTWID = CNTWID_DEF
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_load,
    input  logic [WID-1:0] i_expo,
    input  logic           i_dec,
`ifdef MONTEXP_SKIPLZ_EN
    input  logic           i_scan,
`endif
    output logic           o_bit,
    output logic           o_idx_zero
);

    logic [WID-1:0]    r_expo;
    logic [CNTWID-1:0] r_idx;
    logic              w_dec;

`ifdef MONTEXP_SKIPLZ_EN
    // While scanning, walk past zero bits on our own; stop on a set bit or at bit 0.
    assign w_dec = i_dec | (i_scan & ~o_bit & ~o_idx_zero);
`else
    assign w_dec = i_dec;
`endif

    assign o_bit      = r_expo[r_idx];
    assign o_idx_zero = (r_idx == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_expo <= '0;
            r_idx  <= '0;
        end else if (i_load) begin
            r_expo <= i_expo;
            r_idx  <= CNTWID'(WID - 1);
        end else if (w_dec) begin
            r_idx <= r_idx - 1'b1;
        end
    end

endmodule

// File: rtl/montexp_ctrl.sv
// Left-to-right square-and-multiply exponentiation in the Montgomery domain,
// driving one external Montgomery multiplier. Optional macro: MONTEXP_SKIPLZ_EN.
module montexp_ctrl
    import montexp_pkg::*;
#(
    parameter int WID    = WID_DEF,
    parameter int CNTWID = CNTWID_DEF
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_start,
    input  logic [WID-1:0] i_base,
    input  logic [WID-1:0] i_expo,
    input  logic [WID-1:0] i_m,
    input  logic [WID-1:0] i_onem,
    output logic [WID-1:0] o_r,
    output logic           o_vld,
    output logic           o_busy,
    output logic [WID-1:0] o_mp_a,
    output logic [WID-1:0] o_mp_b,
    output logic [WID-1:0] o_mp_m,
    output logic           o_mp_start,
    input  logic [WID-1:0] i_mp_r,
    input  logic           i_mp_vld
);

    state_t         r_state;
    state_t         w_nxt;
    logic [WID-1:0] r_acc;
    logic [WID-1:0] r_base;
    logic [WID-1:0] r_res;
    logic [WID-1:0] r_mp_a;
    logic [WID-1:0] r_mp_b;
    logic [WID-1:0] r_mp_m;
    logic [WID-1:0] w_acc_nxt;
    logic           w_load;
    logic           w_dec;
    logic           w_res_load;
    logic           w_bit;
    logic           w_idx_zero;
`ifdef MONTEXP_SKIPLZ_EN
    logic           w_scan;
`endif

    montexp_bitsel #(
        .WID    (WID),
        .CNTWID (CNTWID)
    ) u_bitsel (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_load),
        .i_expo     (i_expo),
        .i_dec      (w_dec),
`ifdef MONTEXP_SKIPLZ_EN
        .i_scan     (w_scan),
`endif
        .o_bit      (w_bit),
        .o_idx_zero (w_idx_zero)
    );

    always_comb begin
        w_nxt      = r_state;
        w_acc_nxt  = r_acc;
        w_load     = 1'b0;
        w_dec      = 1'b0;
        w_res_load = 1'b0;
`ifdef MONTEXP_SKIPLZ_EN
        w_scan     = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_load    = 1'b1;
                    w_acc_nxt = i_onem;
`ifdef MONTEXP_SKIPLZ_EN
                    w_nxt     = ST_SCAN;
`else
                    w_nxt     = ST_SQR_REQ;
`endif
                end
            end
            ST_SQR_REQ: w_nxt = ST_SQR_WAIT;
            ST_SQR_WAIT: begin
                if (i_mp_vld) begin
                    w_acc_nxt = i_mp_r;
                    if (w_bit) begin
                        w_nxt = ST_MUL_REQ;
                    end else if (w_idx_zero) begin
                        w_nxt      = ST_DONE;
                        w_res_load = 1'b1;
                    end else begin
                        w_dec = 1'b1;
                        w_nxt = ST_SQR_REQ;
                    end
                end
            end
            ST_MUL_REQ: w_nxt = ST_MUL_WAIT;
            ST_MUL_WAIT: begin
                if (i_mp_vld) begin
                    w_acc_nxt = i_mp_r;
                    if (w_idx_zero) begin
                        w_nxt      = ST_DONE;
                        w_res_load = 1'b1;
                    end else begin
                        w_dec = 1'b1;
                        w_nxt = ST_SQR_REQ;
                    end
                end
            end
            ST_DONE: w_nxt = ST_IDLE;
`ifdef MONTEXP_SKIPLZ_EN
            // First set bit: onem^2..*base collapses to base, so load it directly.
            ST_SCAN: begin
                w_scan = 1'b1;
                if (w_bit) begin
                    w_acc_nxt = r_base;
                    if (w_idx_zero) begin
                        w_nxt      = ST_DONE;
                        w_res_load = 1'b1;
                    end else begin
                        w_dec = 1'b1;
                        w_nxt = ST_SQR_REQ;
                    end
                end else if (w_idx_zero) begin
                    w_nxt      = ST_DONE;
                    w_res_load = 1'b1;
                end
            end
`endif
            default: w_nxt = ST_IDLE;
        endcase
    end

    // Operands are loaded on entry to a request state from the value acc is
    // about to take, so they are already stable in the mp_start cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_base  <= '0;
            r_res   <= '0;
            r_mp_a  <= '0;
            r_mp_b  <= '0;
            r_mp_m  <= '0;
        end else begin
            r_state <= w_nxt;
            r_acc   <= w_acc_nxt;
            if (w_load) begin
                r_base <= i_base;
                r_mp_m <= i_m;
            end else if (w_nxt == ST_IDLE) begin
                r_mp_m <= '0;
            end
            if (w_res_load) begin
                r_res <= w_acc_nxt;
            end
            if (w_nxt == ST_SQR_REQ) begin
                r_mp_a <= w_acc_nxt;
                r_mp_b <= w_acc_nxt;
            end else if (w_nxt == ST_MUL_REQ) begin
                r_mp_a <= w_acc_nxt;
                r_mp_b <= r_base;
            end
        end
    end

    assign o_r        = r_res;
    assign o_vld      = (r_state == ST_DONE);
    assign o_busy     = (r_state != ST_IDLE);
    assign o_mp_start = (r_state == ST_SQR_REQ) || (r_state == ST_MUL_REQ);
    assign o_mp_a     = r_mp_a;
    assign o_mp_b     = r_mp_b;
    assign o_mp_m     = r_mp_m;

endmodule

// File: tb/tb_montexp_ctrl.sv
// Scoreboard bench for montexp_ctrl at WID=8 with a behavioural Montgomery
// multiplier of random 3..12 cycle latency.
module tb_montexp_ctrl;

    typedef struct {
        logic [7:0] r;
        int         pulses;
    } exp_t;

`ifdef MONTEXP_SKIPLZ_EN
    localparam int P_T1 = 3;
    localparam int P_T2 = 0;
    localparam int P_T3 = 14;
`else
    localparam int P_T1 = 10;
    localparam int P_T2 = 8;
    localparam int P_T3 = 16;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] base, expo, m, onem;
    logic [7:0] r;
    logic       vld, busy;
    logic [7:0] mpA, mpB, mpM;
    logic       mpStart;
    logic [7:0] mpR, mdlR;
    logic       mpVld, mdlVld, injVld;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;

    assign mpVld = mdlVld | injVld;
    assign mpR   = injVld ? 8'h55 : mdlR;

    montexp_ctrl #(
        .WID    (8),
        .CNTWID (3)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_base     (base),
        .i_expo     (expo),
        .i_m        (m),
        .i_onem     (onem),
        .o_r        (r),
        .o_vld      (vld),
        .o_busy     (busy),
        .o_mp_a     (mpA),
        .o_mp_b     (mpB),
        .o_mp_m     (mpM),
        .o_mp_start (mpStart),
        .i_mp_r     (mpR),
        .i_mp_vld   (mpVld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // a*b*R^-1 mod mm with R = 256, found by search rather than by inverse
    function automatic logic [7:0] mont(input logic [7:0] a, input logic [7:0] b, input logic [7:0] mm);
        int unsigned p;
        if (mm == 8'd0) return 8'd0;
        p = (int'(a) * int'(b)) % int'(mm);
        for (int t = 0; t < int'(mm); t++) begin
            if ((t * 256) % int'(mm) == p) return 8'(t);
        end
        return 8'd0;
    endfunction

    // Multiplier model: re-reads its operands when producing the result,
    // like the real wrapper, and checks they were held.
    initial begin
        int         cnt;
        logic [7:0] capA, capB, capM;
        cnt = 0;
        capA = '0; capB = '0; capM = '0;
        mdlVld = 1'b0;
        mdlR = '0;
        forever begin
            @(negedge clk);
            mdlVld = 1'b0;
            if (!rst_n) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    checkOutput("operands_held", {mpA, mpB, mpM}, {capA, capB, capM});
                    cnt--;
                    if (cnt == 0) begin
                        mdlVld = 1'b1;
                        mdlR = mont(mpA, mpB, mpM);
                    end
                end
                if (mpStart) begin
                    checkOutput("one_outstanding", cnt, 0);
                    capA = mpA; capB = mpB; capM = mpM;
                    cnt = int'($urandom_range(3, 12));
                end
            end
        end
    end

    // Monitor: pops an expectation on every vld pulse.
    initial begin
        int   pulses;
        exp_t e;
        pulses = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pulses = 0;
            end else begin
                if (mpStart) pulses++;
                if (vld) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_vld", vld, 0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("result", r, e.r);
                        checkOutput("mp_start_count", pulses, e.pulses);
                    end
                    pulses = 0;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] b, input logic [7:0] e, input logic [7:0] mm,
                                 input logic [7:0] one, input logic [7:0] expR, input int expP,
                                 input bit doPush);
        exp_t x;
        @(negedge clk);
        base = b; expo = e; m = mm; onem = one;
        start = 1'b1;
        if (doPush) begin
            x.r = expR;
            x.pulses = expP;
            expQ.push_back(x);
        end
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_start", busy, 1);
    endtask

    task automatic waitDone();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (vld) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL timeout: no vld within 2000 cycles, want vld");
        end
        @(negedge clk);
        checkOutput("idle_after_vld", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        base = '0; expo = '0; m = '0; onem = '0;
        injVld = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", {r, vld, busy, mpStart, mpA, mpB, mpM}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_outputs", {r, vld, busy, mpStart, mpA, mpB, mpM}, 0);

        $display("[TB] test 1: 2^5 mod 13");
        applyStimulus(8'd5, 8'd5, 8'd13, 8'd9, 8'd2, P_T1, 1'b1);
        waitDone();

        $display("[TB] test 2: expo = 0");
        applyStimulus(8'd5, 8'd0, 8'd13, 8'd9, 8'd9, P_T2, 1'b1);
        waitDone();

        // 2^255 mod 13 = 8 (2^12 = 1), Montgomery form 8*9 mod 13 = 7
        $display("[TB] test 3: expo = 0xFF");
        applyStimulus(8'd5, 8'hFF, 8'd13, 8'd9, 8'd7, P_T3, 1'b1);
        waitDone();

        $display("[TB] test 4: perturbation, start while busy, spurious mp_vld");
        applyStimulus(8'd5, 8'd5, 8'd13, 8'd9, 8'd2, P_T1, 1'b1);
        repeat (15) @(negedge clk);
        base = 8'd1; m = 8'd7; expo = 8'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone();
        injVld = 1'b1;
        @(negedge clk);
        injVld = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("idle_after_spurious", busy, 0);
        checkOutput("r_held", r, 8'd2);

        $display("[TB] test 5: reset during SQR_WAIT");
        applyStimulus(8'd5, 8'd5, 8'd13, 8'd9, 8'd0, 0, 1'b0);
        for (int n = 0; n < 50 && !mpStart; n++) @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset_outputs", {r, vld, busy, mpStart, mpA, mpB, mpM}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'd5, 8'd5, 8'd13, 8'd9, 8'd2, P_T1, 1'b1);
        waitDone();

        repeat (5) @(negedge clk);
        checkOutput("queue_empty", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
